fb_bitserial_scheduler: RTL
===========================

// Module: fb_bitserial_scheduler
// PURPOSE
//   Synchronous scheduler for the feedback path. Converts a N_BITS feedback count word into a
//   binary-weighted 1-bit stream. MSB is selected in half the slots, next bit in a quarter, etc.
//   Sequence follows gray-code bit toggling (slot c selects bit N_BITS-1-tz(c), tz = trailing zeros).
//   Double-buffers the word with a valid/ready handshake and swaps only at frame boundaries.
// PARAMETERS
//   N_BITS   10   feedback word width; frame length = 2**N_BITS slots
// PORTS
//   clk_ext      in   1       core clock; all state changes on posedge
//   rstb_ext     in   1       synchronous, active-low reset
//   en           in   1       slot counter advance enable
//   fb_word      in   N_BITS  feedback count word from up/down counter
//   fb_valid     in   1       fb_word valid
//   fb_ready     out  1       shadow register empty; = ~shadow_full (registered, no comb path from fb_valid)
//   clr_underrun in   1       clears sticky underrun
//   out_muxed    out  1       scheduled feedback bit (registered)
//   sel_onehot   out  N_BITS  one-hot of bit driving out_muxed; 0 in idle slot / when en=0
//   frame_start  out  1       1-cycle pulse coincident with slot-0 output
//   underrun     out  1       sticky: frame began with no new word
// BEHAVIOUR
// - Reset (rstb_ext=0 at posedge):
//   - slot counter=0, active word=0, shadow empty, fb_ready=1.
//   - out_muxed=0, sel_onehot=0, frame_start=0, underrun=0.
//   - Reset mid-frame abandons the frame and discards the shadow contents.
// - Handshake:
//   - Transfer when fb_valid & fb_ready at posedge. The word goes to shadow and fb_ready=0 next cycle.
//   - fb_word ignored when fb_ready=0.
// - Slot counter c (N_BITS wide):
//   - Increments when en=1; wraps 2**N_BITS-1 -> 0.
//   - en=0: c holds, out_muxed=0, sel_onehot=0, frame_start=0. Resuming continues at the held slot.
// - Frame boundary (posedge with en=1 and c==0):
//   - Shadow full: active <= shadow, shadow emptied, fb_ready=1 next cycle.
//   - Shadow empty and transfer in the same cycle: word bypasses shadow straight into active; no underrun.
//   - Shadow empty and no transfer: active kept, underrun <= 1.
//   - underrun set has priority over a simultaneous clr_underrun.
// - Output, latency 1 cycle (registered on the posedge that consumes slot c, en=1):
//   - c==0: out_muxed=0, sel_onehot=0, frame_start=1.
//   - c!=0: k = N_BITS-1-tz(c); sel_onehot=1<<k; out_muxed=active[k], using the post-swap active word.
// - Arithmetic:
//   - Slots with tz(c)=t number 2**(N_BITS-1-t), so ones per frame == active word value exactly (0..2**N_BITS-1).
//   - Slot 0 is always the idle slot.
// - clr_underrun: clears underrun next posedge unless set in that same cycle.
// TESTING
// - rstb_ext low 3 cycles, fb_valid=1 -> all outputs 0, fb_ready=1, no word captured.
// - Load 10'h2AB, en=1, count one frame (1024 slots) -> 683 ones. sel_onehot[9] on all 512 odd slots;
//   sel_onehot[0] only at c=512. frame_start once per 1024 cycles.
// - Words 10'h000 and 10'h3FF -> 0 ones and 1023 ones per frame (slot 0 always 0).
// - No write before second frame -> underrun=1 after its slot 0 and 683 ones again.
//   clr_underrun pulse -> underrun=0; clr_underrun coincident with a new underrun -> stays 1.
// - Write A=10'h010, then B=10'h3F0 mid-frame -> fb_ready low until next slot 0.
//   Frame 1 = 16 ones, frame 2 = 1008 ones. Write offered exactly at c==0 with shadow empty -> takes effect that frame.
// - Drop en at c=300 for 20 cycles, then rstb_ext low at c=500 -> counter frozen with outputs 0;
//   after reset counter=0, shadow empty, active=0.

Source files
------------

// File: rtl/fb_bitserial_scheduler_if.sv
// Feedback-word handshake bundle between the up/down counter (master) and the scheduler (slave).
// A word transfers on a posedge where fb_valid and fb_ready are both high; fb_ready is a flop output with no path from fb_valid.
interface fb_bitserial_scheduler_if #(
    parameter int N_BITS = 10
) ();
    logic [N_BITS-1:0] fb_word;
    logic              fb_valid;
    logic              fb_ready;

    modport master (
        output fb_word,
        output fb_valid,
        input  fb_ready
    );

    modport slave (
        input  fb_word,
        input  fb_valid,
        output fb_ready
    );
endinterface

// File: rtl/fb_bitserial_scheduler.sv
// Binary-weighted bit-serial scheduler: slot c emits bit N_BITS-1-tz(c) of the active word,
// with a double-buffered feedback word that swaps in only at slot 0.
module fb_bitserial_scheduler #(
    parameter int N_BITS = 10
) (
    input  logic                   clk_ext,
    input  logic                   rstb_ext,
    input  logic                   en,
    fb_bitserial_scheduler_if.slave fb,
    input  logic                   clr_underrun,
    output logic                   out_muxed,
    output logic [N_BITS-1:0]      sel_onehot,
    output logic                   frame_start,
    output logic                   underrun,
    output logic [N_BITS-1:0]      dbg_slot,
    output logic [N_BITS-1:0]      dbg_active,
    output logic                   dbg_shadow_full
);
    localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    logic [N_BITS-1:0] slot_q, slot_d;
    logic [N_BITS-1:0] active_q, active_d;
    logic [N_BITS-1:0] shadow_q, shadow_d;
    logic              shadow_full_q, shadow_full_d;
    logic              underrun_q, underrun_d;
    logic              out_muxed_q, out_muxed_d;
    logic [N_BITS-1:0] sel_onehot_q, sel_onehot_d;
    logic              frame_start_q, frame_start_d;

    logic              xfer;
    logic              boundary;
    logic              underrun_set;
    logic [IDX_W-1:0]  tz;
    logic [IDX_W-1:0]  bit_idx;

    always_comb begin
        xfer          = fb.fb_valid & ~shadow_full_q;
        boundary      = en & (slot_q == '0);
        underrun_set  = 1'b0;
        slot_d        = slot_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        out_muxed_d   = 1'b0;
        sel_onehot_d  = '0;
        frame_start_d = 1'b0;

        if (en) begin
            slot_d = slot_q + 1'b1;
        end

        // An empty shadow at slot 0 lets a same-cycle transfer bypass straight into active.
        if (boundary) begin
            if (shadow_full_q) begin
                active_d      = shadow_q;
                shadow_full_d = 1'b0;
            end else if (xfer) begin
                active_d = fb.fb_word;
            end else begin
                underrun_set = 1'b1;
            end
        end else if (xfer) begin
            shadow_d      = fb.fb_word;
            shadow_full_d = 1'b1;
        end

        if (underrun_set) begin
            underrun_d = 1'b1;
        end else if (clr_underrun) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end

        // Lowest set bit of the slot number; scanning downward leaves it last.
        tz = '0;
        for (int i = N_BITS - 1; i >= 0; i--) begin
            if (slot_q[i]) begin
                tz = IDX_W'(i);
            end
        end
        bit_idx = IDX_W'(N_BITS - 1) - tz;

        if (en) begin
            if (slot_q == '0) begin
                frame_start_d = 1'b1;
            end else begin
                sel_onehot_d = N_BITS'(1) << bit_idx;
                out_muxed_d  = active_d[bit_idx];
            end
        end
    end

    always_ff @(posedge clk_ext) begin
        if (!rstb_ext) begin
            slot_q        <= '0;
            active_q      <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            underrun_q    <= 1'b0;
            out_muxed_q   <= 1'b0;
            sel_onehot_q  <= '0;
            frame_start_q <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            underrun_q    <= underrun_d;
            out_muxed_q   <= out_muxed_d;
            sel_onehot_q  <= sel_onehot_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign fb.fb_ready       = ~shadow_full_q;
    assign out_muxed         = out_muxed_q;
    assign sel_onehot        = sel_onehot_q;
    assign frame_start       = frame_start_q;
    assign underrun          = underrun_q;
    assign dbg_slot          = slot_q;
    assign dbg_active        = active_q;
    assign dbg_shadow_full   = shadow_full_q;
endmodule
